// File: rtl/pe_dot_accumulator.sv
// pe_dot_accumulator: sums a stream of signed products, then requantizes the sum and returns it over valid/ready
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, len, shift   begin a dot product of len beats with a requant right shift (sampled in IDLE only)
//   in_valid/in_ready   product beat handshake; in_data is a signed PROD_WIDTH product
//   out_valid/out_ready result handshake; out_data is the rounded, saturated result
//   out_acc             raw wrapped accumulator value of the finished dot product
//   busy                high while accumulating or holding a result
module pe_dot_accumulator #(
  parameter int PROD_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int LEN_WIDTH   = 10,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [PROD_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic signed [ACC_WIDTH-1:0] out_acc,
  output logic                        busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0]   W_MAX   = (ACC_WIDTH+1)'(OUT_MAX);
  localparam logic signed [ACC_WIDTH:0]   W_MIN   = (ACC_WIDTH+1)'(OUT_MIN);
  state_t                       r_state, w_next;
  logic signed [ACC_WIDTH-1:0]  r_acc, r_out_acc, w_acc_sum;
  logic signed [OUT_WIDTH-1:0]  r_out_data, w_sat;
  logic [LEN_WIDTH-1:0]         r_cnt, r_len;
  logic [SHIFT_WIDTH-1:0]       r_shift;
  logic                         w_start, w_beat, w_last;
  logic signed [ACC_WIDTH:0]    w_round, w_wide, w_shr;
  assign w_start   = (r_state == IDLE) && start;
  assign w_beat    = (r_state == ACCUM) && in_valid;
  assign w_last    = w_beat && (r_cnt == r_len - 1'b1);
  assign w_acc_sum = r_acc + ACC_WIDTH'(in_data);
  // Rounding add is one bit wider than the accumulator so the half-LSB bias can never wrap
  assign w_round   = (r_shift == '0) ? '0 : (ACC_WIDTH+1)'(1) << (r_shift - 1'b1);
  assign w_wide    = {w_acc_sum[ACC_WIDTH-1], w_acc_sum} + w_round;
  assign w_shr     = w_wide >>> r_shift;
  assign w_sat     = (w_shr > W_MAX) ? OUT_MAX : (w_shr < W_MIN) ? OUT_MIN : w_shr[OUT_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    in_ready  = r_state == ACCUM;
    out_valid = r_state == HOLD;
    busy      = r_state != IDLE;
    if (w_start)                           w_next = (len == '0) ? HOLD : ACCUM;
    else if (w_last)                       w_next = HOLD;
    else if (r_state == HOLD && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      r_out_data <= '0;
      r_out_acc  <= '0;
    end else if (w_start) begin
      r_len      <= len;
      r_shift    <= shift;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_acc  <= '0;
    end else if (w_beat) begin
      r_acc <= w_acc_sum;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_out_data <= w_sat;
        r_out_acc  <= w_acc_sum;
      end
    end
  assign out_data = r_out_data;
  assign out_acc  = r_out_acc;
endmodule

// File: tb/tb_pe_dot_accumulator.sv
// tb_pe_dot_accumulator: randomized scoreboard bench for pe_dot_accumulator
module tb_pe_dot_accumulator;
  logic               clk = 1'b0;
  logic               rst_n, start, in_valid, out_ready;
  logic [9:0]         len;
  logic [4:0]         shift;
  logic signed [15:0] in_data;
  logic               in_ready, out_valid, busy;
  logic signed [7:0]  out_data;
  logic signed [31:0] out_acc;
  int                 checks = 0, errors = 0;
  longint             q_data[$], q_acc[$];
  bit                 done = 0;
  pe_dot_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .shift(shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_acc(out_acc), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void model(input int beats[$], input int s, output longint a, output longint r);
    longint sum = 0, n, d, q;
    logic signed [31:0] w;
    foreach (beats[k]) sum += beats[k];
    w = 32'(sum);
    a = w;
    if (s == 0) q = a;
    else begin
      d = longint'(1) << s;
      n = a + d / 2;
      q = n / d;
      if (n % d != 0 && n < 0) q--;
    end
    r = q > 127 ? 127 : q < -128 ? -128 : q;
  endfunction
  task automatic run_vec(input int n, input int s, input int beats[$], input int mode, input int stall, input int abort_at);
    int i, t;
    bit taken;
    longint a, r;
    if (abort_at < 0) begin
      model(beats, s, a, r);
      q_data.push_back(r);
      q_acc.push_back(a);
    end
    @(posedge clk); #1;
    start = 1; len = 10'(n); shift = 5'(s); out_ready = (stall == 0);
    @(posedge clk); #1;
    start = 0;
    if (n == 0) begin
      chk("len0_valid", out_valid, 1);
      chk("len0_in_ready", in_ready, 0);
    end
    i = 0; t = 0;
    while (i < n && i != abort_at && t < 4000) begin
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? (t % 2 == 0) : ($urandom_range(0, 3) != 0);
      in_data = 16'(beats[i]);
      taken = in_valid && in_ready;
      @(posedge clk); #1;
      t++;
      if (taken) i++;
    end
    in_valid = 0;
    if (i == abort_at) begin
      rst_n = 0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_acc", out_acc, 0);
      @(posedge clk); #1;
      rst_n = 1;
      return;
    end
    if (n > 0) chk("valid_after_last_beat", out_valid, 1);
    for (int k = 0; k < stall; k++) begin
      if (k == 1) begin start = 1; len = 10'd3; in_valid = 1; end
      @(posedge clk); #1;
      chk("hold_in_ready", in_ready, 0);
    end
    start = 0; in_valid = 0; out_ready = 1;
    t = 0;
    while (busy && t < 100) begin @(posedge clk); #1; t++; end
    chk("return_idle_busy", busy, 0);
    chk("return_idle_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 0);
  endtask
  task automatic monitor();
    bit stalled = 0;
    longint pd = 0, pa = 0;
    while (!done) begin
      @(negedge clk);
      if (stalled && out_valid) begin
        chk("stall_data_stable", out_data, pd);
        chk("stall_acc_stable", out_acc, pa);
      end
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          chk("out_data", out_data, q_data.pop_front());
          chk("out_acc", out_acc, q_acc.pop_front());
        end
      end
      stalled = rst_n && out_valid && !out_ready;
      pd = out_data;
      pa = out_acc;
    end
  endtask
  initial begin
    int bq[$];
    rst_n = 0; start = 0; in_valid = 0; out_ready = 0; len = '0; shift = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1;
    fork
      monitor();
      begin
        bq = {11, 22, 33, 44, 55, 66, 77, 88};
        run_vec(8, 0, bq, 0, 0, 3);
        bq = {10, 20, -5, 7};
        run_vec(4, 0, bq, 0, 0, -1);
        bq = {3, 3};
        run_vec(2, 2, bq, 0, 0, -1);
        bq = {-3, -3};
        run_vec(2, 2, bq, 0, 0, -1);
        bq = {100, 100, 100};
        run_vec(3, 0, bq, 0, 0, -1);
        bq = {-200, -200, 0};
        run_vec(3, 0, bq, 0, 0, -1);
        bq = {1000, -2, 3, 4};
        run_vec(4, 3, bq, 1, 5, -1);
        bq = {};
        run_vec(0, 4, bq, 0, 0, -1);
        bq = {32767, 32767, 32767, -32768};
        run_vec(4, 31, bq, 0, 2, -1);
        for (int v = 0; v < 30; v++) begin
          int n, s, mag;
          n = $urandom_range(0, 3) == 0 ? $urandom_range(0, 1) : $urandom_range(2, 12);
          s = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20);
          mag = $urandom_range(0, 1) ? 300 : 32768;
          bq = {};
          for (int k = 0; k < n; k++)
            bq.push_back(mag == 32768 ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 600)) - 300);
          run_vec(n, s, bq, 2, $urandom_range(0, 3), -1);
        end
        repeat (3) @(posedge clk);
        done = 1;
      end
    join
    chk("pending_results", q_data.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
